axis_rr_arbiter: RTL and testbench
==================================

# axis_rr_arbiter

Round-robin arbiter that shares one AXI-Stream word output between `NUM_SRC` word-wide AXI-Stream sources, such as several packed byte-to-word interfaces feeding one downstream consumer. It grants one source at a time for a bounded burst of words and registers the selected word into a single output stage. It tags each word with the source index on `m_axis_tdest`. A per-source enable mask lets software exclude sources from arbitration.

## Interface
- `NUM_SRC`, 4: number of sources; legal values are 2 to 16.
- `LOGIC_SIZE`, 32: word width in bits.
- `MAX_BURST`, 4: maximum words transferred per grant; legal values are 1 to 256.
- `IDX_W`, derived as $clog2(NUM_SRC): width of source indices.

Ports (name, direction, width, meaning):
- `axis_aclk`  in  1  single clock for all logic.
- `axis_reset`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  NUM_SRC*LOGIC_SIZE  flattened source data; source i occupies bits [i*LOGIC_SIZE +: LOGIC_SIZE].
- `s_axis_valid`  in  NUM_SRC  per-source valid.
- `s_axis_ready`  out  NUM_SRC  per-source ready.
- `i_src_enable`  in  NUM_SRC  per-source arbitration enable; quasi-static.
- `m_axis_tdata`  out  LOGIC_SIZE  registered output word.
- `m_axis_tdest`  out  IDX_W  index of the source that produced `m_axis_tdata`.
- `m_axis_valid`  out  1  output valid.
- `m_axis_ready`  in  1  downstream ready.
- `o_grant_active`  out  1  high while in state GRANT.
- `o_grant_idx`  out  IDX_W  currently or last granted source.

## Operation
State machine:
- **IDLE**
  - Request vector is `req = s_axis_valid & i_src_enable`.
  - If `req` is nonzero, the block picks the first set bit searching upward from `rr_ptr` and wrapping modulo NUM_SRC. It loads `grant` with that index, clears `burst_cnt`, and moves to GRANT.
  - If `req` is zero, the block stays in IDLE.
  - No transfer occurs in an IDLE cycle.
- **GRANT**
  - `s_axis_ready[grant]` = `i_src_enable[grant]` && (!m_axis_valid || m_axis_ready).
  - All other ready bits are 0.
  - On a transfer (`s_axis_valid[grant] && s_axis_ready[grant]`), the block loads `m_axis_tdata`, sets `m_axis_tdest = grant`, and increments `burst_cnt`.

Release conditions (GRANT → IDLE). On any release, `rr_ptr <= (grant+1) mod NUM_SRC`, computed explicitly and not by relying on bit-width wrap.
- A transfer occurs with `burst_cnt == MAX_BURST-1`.
- `s_axis_valid[grant]` is 0 in a GRANT cycle. This releases immediately, including in the first GRANT cycle.
- `i_src_enable[grant]` is 0 in a GRANT cycle.
- Backpressure alone (m_axis_ready low) never releases a grant.

Output register:
- A load sets `m_axis_valid = 1`.
- `m_axis_ready && m_axis_valid` with no load in the same cycle clears `m_axis_valid`.
- A load and a drain in the same cycle leave `m_axis_valid = 1` with the new data.
- While `m_axis_valid && !m_axis_ready`, `m_axis_tdata` and `m_axis_tdest` hold stable.

Widths:
- `burst_cnt` is $clog2(MAX_BURST+1) bits.
- `rr_ptr` and `grant` are IDX_W bits.
- If NUM_SRC is not a power of two, indices ≥ NUM_SRC are never produced.

## Timing
- **Reset:** asynchronous; takes effect immediately. After reset:
  - state = IDLE, `rr_ptr` = 0, `grant` = 0, `burst_cnt` = 0.
  - `m_axis_valid` = 0, `m_axis_tdata` = 0, `m_axis_tdest` = 0.
  - `s_axis_ready` = 0, `o_grant_active` = 0, `o_grant_idx` = 0.
  - A word held in the output register at reset is discarded.
- **Arbitration latency:** 1 cycle. A request seen in IDLE at edge N gives `s_axis_ready` high during cycle N+1.
- **Data latency:** a word accepted at edge N appears on `m_axis_tdata` with `m_axis_valid` high after edge N.
- **Throughput:** with no backpressure and continuous requests, MAX_BURST words per MAX_BURST+1 cycles, because there is one IDLE gap per grant.
- **Ready logic:** `s_axis_ready` is combinational from registered state and `m_axis_ready`. There is no combinational path from `s_axis_valid` to `s_axis_ready`.

## Test plan
1. **Reset:** assert `axis_reset` with all sources valid → every output at its reset value; `s_axis_ready` = 0. After deassertion, source 0 is granted first.
2. **Single-source burst:** only source 0 valid, 6 words 0xA0..0xA5, MAX_BURST = 4, `m_axis_ready` = 1 → 0xA0–0xA3 appear back-to-back with tdest = 0, then a 1-cycle gap, then 0xA4–0xA5.
3. **All sources valid:** all four sources valid continuously, enable = 4'b1111 → grant order 0, 1, 2, 3, 0, 4 words each, with exactly one gap cycle between bursts.
4. **Backpressure:** drop `m_axis_ready` for 3 cycles while `m_axis_valid` = 1 → tdata and tdest held stable, `s_axis_ready[grant]` = 0, and the grant is retained. Transfers resume in the cycle `m_axis_ready` rises.
5. **Early release:** source 2 drops valid after 2 words → release on that cycle, `rr_ptr` = 3, and the next grant goes to source 3 even though source 0 is requesting.
6. **Enable mask and reset mid-burst:** enable = 4'b1011 with all sources valid → source 2 is never granted (order 0, 1, 3, 0). Then assert `axis_reset` mid-burst → `m_axis_valid` drops immediately and the next grant after reset is source 0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// Round-robin AXI-Stream arbiter: NUM_SRC sources share one registered output, bounded bursts per grant.
// One IDLE cycle per grant; source ready is combinational from state and m_axis_ready, so backpressure stalls without losing the grant.
module axis_rr_arbiter #(
    parameter int NUM_SRC    = 4,
    parameter int LOGIC_SIZE = 32,
    parameter int MAX_BURST  = 4,
    parameter int IDX_W      = $clog2(NUM_SRC)
) (
    input  logic                          axis_aclk,
    input  logic                          axis_reset,
    input  logic [NUM_SRC*LOGIC_SIZE-1:0] s_axis_tdata,
    input  logic [NUM_SRC-1:0]            s_axis_valid,
    output logic [NUM_SRC-1:0]            s_axis_ready,
    input  logic [NUM_SRC-1:0]            i_src_enable,
    output logic [LOGIC_SIZE-1:0]         m_axis_tdata,
    output logic [IDX_W-1:0]              m_axis_tdest,
    output logic                          m_axis_valid,
    input  logic                          m_axis_ready,
    output logic                          o_grant_active,
    output logic [IDX_W-1:0]              o_grant_idx
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_SRC  = IDX_W'(NUM_SRC - 1);

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_grant;
    logic [CNT_W-1:0]        r_burst_cnt;
    logic                    r_m_valid;
    logic [LOGIC_SIZE-1:0]   r_m_tdata;
    logic [IDX_W-1:0]        r_m_tdest;

    logic [NUM_SRC-1:0]      w_req;
    logic [IDX_W:0]          w_scan;
    logic [IDX_W-1:0]        w_pick_idx;
    logic                    w_pick_vld;
    logic                    w_sel_vld;
    logic                    w_sel_en;
    logic                    w_out_free;
    logic                    w_sel_rdy;
    logic                    w_xfer;
    logic                    w_release;
    logic [IDX_W-1:0]        w_grant_inc;
    logic [LOGIC_SIZE-1:0]   w_sel_dat;

    assign w_req = s_axis_valid & i_src_enable;

    // Scan downward so the lowest offset from r_rr_ptr is the last (winning) assignment.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_idx = '0;
        w_scan     = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(NUM_SRC)) begin
                w_scan = w_scan - (IDX_W+1)'(NUM_SRC);
            end
            if (w_req[w_scan[IDX_W-1:0]]) begin
                w_pick_vld = 1'b1;
                w_pick_idx = w_scan[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_dat = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == IDX_W'(i)) begin
                w_sel_dat = s_axis_tdata[i*LOGIC_SIZE +: LOGIC_SIZE];
            end
        end
    end

    assign w_sel_vld   = s_axis_valid[r_grant];
    assign w_sel_en    = i_src_enable[r_grant];
    assign w_out_free  = !r_m_valid || m_axis_ready;
    assign w_sel_rdy   = w_sel_en && w_out_free;
    assign w_xfer      = (r_state == ST_GRANT) && w_sel_vld && w_sel_rdy;
    assign w_release   = (r_state == ST_GRANT) &&
                         (!w_sel_vld || !w_sel_en || (w_xfer && (r_burst_cnt == LAST_BEAT)));
    assign w_grant_inc = (r_grant == LAST_SRC) ? '0 : r_grant + IDX_W'(1);

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_vld) w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_release)  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_ready   = '0;
        o_grant_active = (r_state == ST_GRANT);
        if (r_state == ST_GRANT) begin
            s_axis_ready[r_grant] = w_sel_rdy;
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_burst_cnt <= '0;
            r_m_valid   <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tdest   <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_pick_vld) begin
                r_grant     <= w_pick_idx;
                r_burst_cnt <= '0;
            end else if (w_xfer) begin
                r_burst_cnt <= r_burst_cnt + CNT_W'(1);
            end
            if (w_release) begin
                r_rr_ptr <= w_grant_inc;
            end
            // A load wins over a drain so back-to-back words never bubble.
            if (w_xfer) begin
                r_m_valid <= 1'b1;
                r_m_tdata <= w_sel_dat;
                r_m_tdest <= r_grant;
            end else if (m_axis_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_axis_valid = r_m_valid;
    assign m_axis_tdata = r_m_tdata;
    assign m_axis_tdest = r_m_tdest;
    assign o_grant_idx  = r_grant;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: per-cycle vector table plus hand sequences for arbitration order, early release, masking and reset.
module tb_axis_rr_arbiter;
    localparam int NS = 4;
    localparam int LS = 32;

    logic            axis_aclk = 1'b0;
    logic            axis_reset;
    logic [NS*LS-1:0] s_axis_tdata;
    logic [NS-1:0]   s_axis_valid;
    logic [NS-1:0]   s_axis_ready;
    logic [NS-1:0]   i_src_enable;
    logic [LS-1:0]   m_axis_tdata;
    logic [1:0]      m_axis_tdest;
    logic            m_axis_valid;
    logic            m_axis_ready;
    logic            o_grant_active;
    logic [1:0]      o_grant_idx;

    axis_rr_arbiter #(.NUM_SRC(NS), .LOGIC_SIZE(LS), .MAX_BURST(4)) dut (
        .axis_aclk      (axis_aclk),
        .axis_reset     (axis_reset),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_valid   (s_axis_valid),
        .s_axis_ready   (s_axis_ready),
        .i_src_enable   (i_src_enable),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tdest   (m_axis_tdest),
        .m_axis_valid   (m_axis_valid),
        .m_axis_ready   (m_axis_ready),
        .o_grant_active (o_grant_active),
        .o_grant_idx    (o_grant_idx)
    );

    always #5 axis_aclk = ~axis_aclk;

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic        mrdy;
        logic [31:0] dat;
        logic [3:0]  e_rdy;
        logic        e_act;
        logic [1:0]  e_gidx;
        logic        e_mvld;
        logic [31:0] e_tdata;
        logic [1:0]  e_tdest;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] vld, input logic mrdy, input logic [31:0] dat,
                       input logic [3:0] e_rdy, input logic e_act, input logic [1:0] e_gidx,
                       input logic e_mvld, input logic [31:0] e_tdata, input logic [1:0] e_tdest);
        vec_t v;
        v.rst = rst; v.vld = vld; v.mrdy = mrdy; v.dat = dat;
        v.e_rdy = e_rdy; v.e_act = e_act; v.e_gidx = e_gidx;
        v.e_mvld = e_mvld; v.e_tdata = e_tdata; v.e_tdest = e_tdest;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic do_reset();
        axis_reset   = 1'b1;
        s_axis_valid = '0;
        s_axis_tdata = '0;
        m_axis_ready = 1'b1;
        i_src_enable = 4'b1111;
        repeat (2) @(posedge axis_aclk);
        @(negedge axis_aclk);
        axis_reset = 1'b0;
        tick();
    endtask

    int   cnt [NS];
    int   widx;
    logic [3:0] xfer;
    int   rdy2_hits;
    logic prev_act;
    logic [1:0] grants[$];

    initial begin
        // Reset with every source requesting: outputs must sit at reset values.
        axis_reset   = 1'b1;
        s_axis_valid = 4'b1111;
        i_src_enable = 4'b1111;
        m_axis_ready = 1'b1;
        s_axis_tdata = {32'h3, 32'h2, 32'h1, 32'h0};
        repeat (2) @(posedge axis_aclk);
        @(negedge axis_aclk);
        chk("rst_ready", s_axis_ready, 4'b0000);
        chk("rst_mvalid", m_axis_valid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tdest", m_axis_tdest, 0);
        chk("rst_active", o_grant_active, 0);
        chk("rst_gidx", o_grant_idx, 0);
        axis_reset = 1'b0;
        tick();
        chk("post_rst_active", o_grant_active, 1);
        chk("post_rst_gidx", o_grant_idx, 0);
        chk("post_rst_ready", s_axis_ready, 4'b0001);

        // Single-source burst of six words, then async reset, then backpressure on source 1.
        add(0, 4'b0001, 1, 32'hA0, 4'b0000, 0, 0, 0, 32'h00, 0);
        add(0, 4'b0001, 1, 32'hA0, 4'b0001, 1, 0, 0, 32'h00, 0);
        add(0, 4'b0001, 1, 32'hA1, 4'b0001, 1, 0, 1, 32'hA0, 0);
        add(0, 4'b0001, 1, 32'hA2, 4'b0001, 1, 0, 1, 32'hA1, 0);
        add(0, 4'b0001, 1, 32'hA3, 4'b0001, 1, 0, 1, 32'hA2, 0);
        add(0, 4'b0001, 1, 32'hA4, 4'b0000, 0, 0, 1, 32'hA3, 0);
        add(0, 4'b0001, 1, 32'hA4, 4'b0001, 1, 0, 0, 32'hA3, 0);
        add(0, 4'b0001, 1, 32'hA5, 4'b0001, 1, 0, 1, 32'hA4, 0);
        add(0, 4'b0000, 1, 32'hA5, 4'b0001, 1, 0, 1, 32'hA5, 0);
        add(0, 4'b0000, 1, 32'h00, 4'b0000, 0, 0, 0, 32'hA5, 0);
        add(1, 4'b0000, 1, 32'h00, 4'b0000, 0, 0, 0, 32'h00, 0);
        add(0, 4'b0010, 1, 32'hB0, 4'b0000, 0, 0, 0, 32'h00, 0);
        add(0, 4'b0010, 1, 32'hB0, 4'b0010, 1, 1, 0, 32'h00, 0);
        add(0, 4'b0010, 0, 32'hB1, 4'b0000, 1, 1, 1, 32'hB0, 1);
        add(0, 4'b0010, 0, 32'hB1, 4'b0000, 1, 1, 1, 32'hB0, 1);
        add(0, 4'b0010, 0, 32'hB1, 4'b0000, 1, 1, 1, 32'hB0, 1);
        add(0, 4'b0010, 1, 32'hB1, 4'b0010, 1, 1, 1, 32'hB0, 1);
        add(0, 4'b0010, 1, 32'hB2, 4'b0010, 1, 1, 1, 32'hB1, 1);
        add(0, 4'b0000, 1, 32'hB3, 4'b0010, 1, 1, 1, 32'hB2, 1);
        add(0, 4'b0000, 1, 32'hB3, 4'b0000, 0, 1, 0, 32'hB2, 1);

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            axis_reset   = vecs[i].rst;
            s_axis_valid = vecs[i].vld;
            m_axis_ready = vecs[i].mrdy;
            s_axis_tdata = {4{vecs[i].dat}};
            @(negedge axis_aclk);
            chk($sformatf("v%0d_ready", i),  s_axis_ready,   vecs[i].e_rdy);
            chk($sformatf("v%0d_active", i), o_grant_active, vecs[i].e_act);
            chk($sformatf("v%0d_gidx", i),   o_grant_idx,    vecs[i].e_gidx);
            chk($sformatf("v%0d_mvalid", i), m_axis_valid,   vecs[i].e_mvld);
            chk($sformatf("v%0d_tdata", i),  m_axis_tdata,   vecs[i].e_tdata);
            chk($sformatf("v%0d_tdest", i),  m_axis_tdest,   vecs[i].e_tdest);
            tick();
        end
        axis_reset = 1'b0;

        // All sources valid: order 0,1,2,3,0, four words each, one gap cycle per grant.
        do_reset();
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        widx = 0;
        for (int c = 0; c < 30; c++) begin
            s_axis_valid = 4'b1111;
            for (int i = 0; i < NS; i++) s_axis_tdata[i*LS +: LS] = 32'h100 * i + cnt[i];
            @(negedge axis_aclk);
            if (m_axis_valid) begin
                if (widx < 20) begin
                    chk($sformatf("rr_w%0d_tdest", widx), m_axis_tdest, (widx / 4) % 4);
                    chk($sformatf("rr_w%0d_tdata", widx), m_axis_tdata,
                        32'h100 * ((widx / 4) % 4) + (widx / 16) * 4 + widx % 4);
                    chk($sformatf("rr_w%0d_cycle", widx), c, 2 + widx + widx / 4);
                end
                widx++;
            end
            xfer = s_axis_ready & s_axis_valid;
            tick();
            for (int i = 0; i < NS; i++) if (xfer[i]) cnt[i]++;
        end
        chk("rr_word_count_ge20", (widx >= 20), 1);

        // Early release: source 2 drops valid after two words; source 3 wins over source 0.
        do_reset();
        s_axis_valid = 4'b0100;
        s_axis_tdata = {32'h33, 32'h22, 32'h11, 32'h00};
        tick();
        @(negedge axis_aclk);
        chk("er_gidx2", o_grant_idx, 2);
        chk("er_ready2", s_axis_ready, 4'b0100);
        tick();
        tick();
        s_axis_valid = 4'b1001;
        @(negedge axis_aclk);
        chk("er_tdest2", m_axis_tdest, 2);
        chk("er_still_grant", o_grant_active, 1);
        tick();
        @(negedge axis_aclk);
        chk("er_released", o_grant_active, 0);
        tick();
        @(negedge axis_aclk);
        chk("er_next_active", o_grant_active, 1);
        chk("er_next_gidx3", o_grant_idx, 3);
        chk("er_next_ready3", s_axis_ready, 4'b1000);

        // Enable mask 1011: source 2 never granted; then async reset mid-burst.
        do_reset();
        i_src_enable = 4'b1011;
        s_axis_valid = 4'b1111;
        rdy2_hits = 0;
        prev_act = 1'b0;
        for (int c = 0; c < 18; c++) begin
            @(negedge axis_aclk);
            if (s_axis_ready[2]) rdy2_hits++;
            if (o_grant_active && !prev_act) grants.push_back(o_grant_idx);
            prev_act = o_grant_active;
            tick();
        end
        chk("mask_ready2_hits", rdy2_hits, 0);
        chk("mask_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mask_grant%0d", i), (i < grants.size()) ? {1'b0, grants[i]} : 3'h7,
                (i == 0) ? 0 : (i == 1) ? 1 : (i == 2) ? 3 : 0);
        end
        #2;
        chk("mid_pre_mvalid", m_axis_valid, 1);
        axis_reset = 1'b1;
        #1;
        chk("mid_rst_mvalid", m_axis_valid, 0);
        chk("mid_rst_active", o_grant_active, 0);
        chk("mid_rst_ready", s_axis_ready, 4'b0000);
        @(negedge axis_aclk);
        axis_reset = 1'b0;
        tick();
        chk("mid_after_active", o_grant_active, 1);
        chk("mid_after_gidx0", o_grant_idx, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
